// File: rtl/parking_gate_ctrl.sv
// Gate front-end: edge-detects entry/exit requests, queues them and serializes one clean
// car_entered/car_exited event per car. Optional reject counter: PARKING_GATE_REJECT_CNT_EN.
module parking_gate_ctrl #(
    parameter int OPEN_CYCLES = 4,
    parameter int QDEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_in,
    input  logic        req_in_uni,
    input  logic        req_out,
    input  logic        req_out_uni,
    input  logic        uni_is_vacated_space,
    input  logic        is_vacated_space,
    output logic        car_entered,
    output logic        is_uni_car_enterd,
    output logic        car_exited,
    output logic        is_uni_car_exited,
    output logic        barrier_open,
    output logic        reject,
    output logic        drop,
    output logic        busy,
    output logic [15:0] rejected_cnt
);
    // state | meaning
    // IDLE  | waiting; pops exit queue first, then entry queue
    // CHECK | entry vacancy decision (exits pass straight through)
    // PULSE | one-cycle car_entered / car_exited
    // HOLD  | barrier held open, down-counter to terminal count 0
    typedef enum logic [1:0] {IDLE, CHECK, PULSE, HOLD} state_t;

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;

    state_t          state_q, state_d;
    logic            dir_exit_q, dir_exit_d;
    logic            cur_q, cur_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            reject_q, reject_d;
    logic            drop_q, drop_d;
    logic            req_in_q, req_out_q;
    logic [QDEPTH-1:0] in_mem_q, in_mem_d, out_mem_q, out_mem_d;
    logic [AW:0]     in_wr_q, in_wr_d, in_rd_q, in_rd_d;
    logic [AW:0]     out_wr_q, out_wr_d, out_rd_q, out_rd_d;

    logic push_in, push_out, pop_in, pop_out;
    logic in_full, in_empty, out_full, out_empty, accept;

    assign push_in   = req_in & ~req_in_q;
    assign push_out  = req_out & ~req_out_q;
    assign in_empty  = (in_wr_q == in_rd_q);
    assign out_empty = (out_wr_q == out_rd_q);
    assign in_full   = (in_wr_q[AW] != in_rd_q[AW]) && (in_wr_q[AW-1:0] == in_rd_q[AW-1:0]);
    assign out_full  = (out_wr_q[AW] != out_rd_q[AW]) && (out_wr_q[AW-1:0] == out_rd_q[AW-1:0]);
    // University cars may overflow into the free area.
    assign accept    = cur_q ? (uni_is_vacated_space | is_vacated_space) : is_vacated_space;

    always_comb begin
        state_d    = state_q;
        dir_exit_d = dir_exit_q;
        cur_d      = cur_q;
        cnt_d      = cnt_q;
        reject_d   = 1'b0;
        pop_in     = 1'b0;
        pop_out    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!out_empty) begin
                    pop_out    = 1'b1;
                    cur_d      = out_mem_q[out_rd_q[AW-1:0]];
                    dir_exit_d = 1'b1;
                    state_d    = CHECK;
                end else if (!in_empty) begin
                    pop_in     = 1'b1;
                    cur_d      = in_mem_q[in_rd_q[AW-1:0]];
                    dir_exit_d = 1'b0;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                if (dir_exit_q || accept) begin
                    state_d = PULSE;
                end else begin
                    reject_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            PULSE: begin
                state_d = HOLD;
                cnt_d   = CW'(OPEN_CYCLES - 1);
            end
            HOLD: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Fullness is taken from the registered pointers, i.e. before any same-edge pop.
    always_comb begin
        in_mem_d  = in_mem_q;
        in_wr_d   = in_wr_q;
        in_rd_d   = in_rd_q;
        out_mem_d = out_mem_q;
        out_wr_d  = out_wr_q;
        out_rd_d  = out_rd_q;
        drop_d    = (push_in & in_full) | (push_out & out_full);
        if (push_in && !in_full) begin
            in_mem_d[in_wr_q[AW-1:0]] = req_in_uni;
            in_wr_d = in_wr_q + 1'b1;
        end
        if (push_out && !out_full) begin
            out_mem_d[out_wr_q[AW-1:0]] = req_out_uni;
            out_wr_d = out_wr_q + 1'b1;
        end
        if (pop_in)  in_rd_d  = in_rd_q + 1'b1;
        if (pop_out) out_rd_d = out_rd_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dir_exit_q <= 1'b0;
            cur_q      <= 1'b0;
            cnt_q      <= '0;
            reject_q   <= 1'b0;
            drop_q     <= 1'b0;
            req_in_q   <= 1'b0;
            req_out_q  <= 1'b0;
            in_mem_q   <= '0;
            in_wr_q    <= '0;
            in_rd_q    <= '0;
            out_mem_q  <= '0;
            out_wr_q   <= '0;
            out_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            dir_exit_q <= dir_exit_d;
            cur_q      <= cur_d;
            cnt_q      <= cnt_d;
            reject_q   <= reject_d;
            drop_q     <= drop_d;
            req_in_q   <= req_in;
            req_out_q  <= req_out;
            in_mem_q   <= in_mem_d;
            in_wr_q    <= in_wr_d;
            in_rd_q    <= in_rd_d;
            out_mem_q  <= out_mem_d;
            out_wr_q   <= out_wr_d;
            out_rd_q   <= out_rd_d;
        end
    end

`ifdef PARKING_GATE_REJECT_CNT_EN
    logic [15:0] rej_cnt_q, rej_cnt_d;

    always_comb begin
        rej_cnt_d = rej_cnt_q;
        if (reject_d && rej_cnt_q != 16'hFFFF) rej_cnt_d = rej_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rej_cnt_q <= '0;
        else        rej_cnt_q <= rej_cnt_d;
    end

    assign rejected_cnt = rej_cnt_q;
`else
    assign rejected_cnt = '0;
`endif

    assign busy              = (state_q != IDLE);
    assign barrier_open      = (state_q == PULSE) || (state_q == HOLD);
    assign car_entered       = (state_q == PULSE) && !dir_exit_q;
    assign car_exited        = (state_q == PULSE) && dir_exit_q;
    assign is_uni_car_enterd = busy && !dir_exit_q && cur_q;
    assign is_uni_car_exited = busy && dir_exit_q && cur_q;
    assign reject            = reject_q;
    assign drop              = drop_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed vector bench for parking_gate_ctrl (OPEN_CYCLES=4, QDEPTH=4).
module tb_parking_gate_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_in, req_in_uni, req_out, req_out_uni;
    logic        uni_is_vacated_space, is_vacated_space;
    logic        car_entered, is_uni_car_enterd, car_exited, is_uni_car_exited;
    logic        barrier_open, reject, drop, busy;
    logic [15:0] rejected_cnt;

`ifdef PARKING_GATE_REJECT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    parking_gate_ctrl #(.OPEN_CYCLES(4), .QDEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_in(req_in), .req_in_uni(req_in_uni),
        .req_out(req_out), .req_out_uni(req_out_uni),
        .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
        .car_entered(car_entered), .is_uni_car_enterd(is_uni_car_enterd),
        .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
        .barrier_open(barrier_open), .reject(reject), .drop(drop), .busy(busy),
        .rejected_cnt(rejected_cnt)
    );

    always #5 clk = ~clk;

    // in  = {req_in, req_in_uni, req_out, req_out_uni, uni_vac, vac}
    // exp = {car_entered, uni_en, car_exited, uni_ex, barrier, reject, drop, busy}
    typedef struct {
        logic [5:0]  in;
        logic [7:0]  exp;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   nvec = 0;
    int   nerr = 0;

    function automatic logic [7:0] outs();
        return {car_entered, is_uni_car_enterd, car_exited, is_uni_car_exited,
                barrier_open, reject, drop, busy};
    endfunction

    function automatic logic [15:0] exp_cnt(input logic [15:0] c);
        return CNT_EN ? c : 16'd0;
    endfunction

    task automatic add(input logic [5:0] in, input logic [7:0] exp, input logic [15:0] cnt,
                       input int rep);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        v.cnt = cnt;
        for (int r = 0; r < rep; r++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] in);
        {req_in, req_in_uni, req_out, req_out_uni, uni_is_vacated_space, is_vacated_space} = in;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(6'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int ce_n, cx_n, dp_n, rj_n, bo_n;

    initial begin
        rst_n = 1'b0;
        drive(6'b0);

        // free entry, vac=1
        add(6'b10_00_01, 8'b0000_0000, 16'd0, 1);
        add(6'b10_00_01, 8'b0000_0001, 16'd0, 1);
        add(6'b00_00_01, 8'b1000_1001, 16'd0, 1);
        add(6'b00_00_01, 8'b0000_1001, 16'd0, 4);
        add(6'b00_00_01, 8'b0000_0000, 16'd0, 2);
        // university entry overflowing into the free area
        add(6'b11_00_01, 8'b0000_0000, 16'd0, 1);
        add(6'b01_00_01, 8'b0100_0001, 16'd0, 1);
        add(6'b01_00_01, 8'b1100_1001, 16'd0, 1);
        add(6'b01_00_01, 8'b0100_1001, 16'd0, 4);
        add(6'b00_00_01, 8'b0000_0000, 16'd0, 1);
        // refused free entry, both flags low
        add(6'b10_00_00, 8'b0000_0000, 16'd0, 1);
        add(6'b00_00_00, 8'b0000_0001, 16'd0, 1);
        add(6'b00_00_00, 8'b0000_0100, 16'd1, 1);
        add(6'b00_00_00, 8'b0000_0000, 16'd1, 1);
        // simultaneous free entry and university exit
        add(6'b10_11_01, 8'b0000_0000, 16'd1, 1);
        add(6'b00_00_01, 8'b0001_0001, 16'd1, 1);
        add(6'b00_00_01, 8'b0011_1001, 16'd1, 1);
        add(6'b00_00_01, 8'b0001_1001, 16'd1, 4);
        add(6'b00_00_01, 8'b0000_0000, 16'd1, 1);
        add(6'b00_00_01, 8'b0000_0001, 16'd1, 1);
        add(6'b00_00_01, 8'b1000_1001, 16'd1, 1);
        add(6'b00_00_01, 8'b0000_1001, 16'd1, 4);
        add(6'b00_00_01, 8'b0000_0000, 16'd1, 1);

        repeat (2) @(negedge clk);
        check("reset_outs", {8'h00, outs()}, 16'h0000);
        check("reset_cnt", rejected_cnt, 16'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].in);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_outs", i), {8'h00, outs()}, {8'h00, vecs[i].exp});
            check($sformatf("vec%0d_cnt", i), rejected_cnt, exp_cnt(vecs[i].cnt));
        end

        // FIFO overflow: two exits keep the FSM busy while 6 entry edges arrive
        do_reset();
        ce_n = 0; cx_n = 0; dp_n = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            drive({(c == 1 || c == 3 || c == 5 || c == 7 || c == 9 || c == 11), 1'b0,
                   (c == 0 || c == 2), 1'b0, 1'b0, 1'b1});
            @(posedge clk);
            #1;
            ce_n += int'(car_entered);
            cx_n += int'(car_exited);
            dp_n += int'(drop);
        end
        check("ovf_entered", 16'(ce_n), 16'd4);
        check("ovf_exited", 16'(cx_n), 16'd2);
        check("ovf_drop_range", 16'(dp_n >= 1 && dp_n <= 2), 16'd1);
        check("ovf_idle", {15'd0, busy}, 16'd0);

        // reset while the barrier is held open, with one entry still queued
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive({(c == 0 || c == 2), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
            @(posedge clk);
            #1;
        end
        check("hold_barrier_open", {15'd0, barrier_open}, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_barrier_close", {15'd0, barrier_open}, 16'd0);
        check("async_busy_clear", {15'd0, busy}, 16'd0);
        drive(6'b00_00_01);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ce_n = 0; cx_n = 0; bo_n = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            ce_n += int'(car_entered);
            cx_n += int'(car_exited);
            bo_n += int'(barrier_open);
        end
        check("flushed_no_pulse", 16'(ce_n + cx_n), 16'd0);
        check("flushed_barrier", 16'(bo_n), 16'd0);

        // three refused entries
        ce_n = 0; rj_n = 0; bo_n = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            drive({(c == 0 || c == 3 || c == 6), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
            @(posedge clk);
            #1;
            ce_n += int'(car_entered);
            rj_n += int'(reject);
            bo_n += int'(barrier_open);
        end
        check("refuse_rejects", 16'(rj_n), 16'd3);
        check("refuse_no_entry", 16'(ce_n), 16'd0);
        check("refuse_barrier", 16'(bo_n), 16'd0);
        check("refuse_cnt", rejected_cnt, exp_cnt(16'd3));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
